// File: rtl/mult_share_ctrl_if.sv
// Request, core and result channels of the shared multiplier scheduler.
// slave is the scheduler side; master is the requesters/core/consumer side.
interface mult_share_ctrl_if #(
    parameter int N   = 16,
    parameter int R   = 4,
    parameter int IDW = (R > 1) ? $clog2(R) : 1
);
    logic [R-1:0]   req_valid;
    logic [R*N-1:0] req_a;
    logic [R*N-1:0] req_b;
    logic [R-1:0]   req_ready;
    logic           m_start;
    logic [N-1:0]   m_a;
    logic [N-1:0]   m_b;
    logic           m_done;
    logic [2*N-1:0] m_p;
    logic           res_valid;
    logic           res_ready;
    logic [IDW-1:0] res_id;
    logic [2*N-1:0] res_p;
    logic           res_err;

    modport slave (
        input  req_valid, req_a, req_b, m_done, m_p, res_ready,
        output req_ready, m_start, m_a, m_b, res_valid, res_id, res_p,
               res_err
    );

    modport master (
        output req_valid, req_a, req_b, m_done, m_p, res_ready,
        input  req_ready, m_start, m_a, m_b, res_valid, res_id, res_p,
               res_err
    );
endinterface

// File: rtl/mult_share_ctrl.sv
// Round-robin scheduler sharing one iterative multiplier core among
// R requesters, with a watchdog on the core's done flag.
module mult_share_ctrl #(
    parameter int N   = 16,
    parameter int R   = 4,
    parameter int TMO = N + 4
) (
    input logic              clk,
    input logic              rst,
    mult_share_ctrl_if.slave bus
);
    localparam int IDW = (R > 1) ? $clog2(R) : 1;
    localparam int WW  = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [WW-1:0]  TLIM = WW'(TMO - 1);
    localparam logic [IDW-1:0] LAST = IDW'(R - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state, nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id;
    logic [WW-1:0]  wcnt;
    logic [N-1:0]   a_q, b_q;
    logic [2*N-1:0] p_q;
    logic           err_q;
    logic [IDW-1:0] gnt;
    logic           found;
    logic           expire;

    // Scan downwards so the requester closest to ptr overwrites the rest.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = R - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(ptr) + k) % R]) begin
                found = 1'b1;
                gnt   = IDW'((int'(ptr) + k) % R);
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && found && !rst)
            bus.req_ready[gnt] = 1'b1;
    end

    assign expire = (wcnt == TLIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (found) nxt = ISSUE;
            ISSUE:   nxt = WAIT;
            WAIT:    if (bus.m_done || expire) nxt = RESP;
            RESP:    if (bus.res_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            id    <= '0;
            wcnt  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            err_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        a_q <= bus.req_a[gnt*N +: N];
                        b_q <= bus.req_b[gnt*N +: N];
                        id  <= gnt;
                    end
                end
                ISSUE: wcnt <= '0;
                WAIT: begin
                    wcnt <= wcnt + 1'b1;
                    // A done in the expiry cycle still delivers the product.
                    if (bus.m_done) begin
                        p_q   <= bus.m_p;
                        err_q <= 1'b0;
                    end else if (expire) begin
                        p_q   <= '0;
                        err_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.res_ready)
                        ptr <= (id == LAST) ? '0 : id + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.m_start   = (state == ISSUE);
    assign bus.m_a       = a_q;
    assign bus.m_b       = b_q;
    assign bus.res_valid = (state == RESP);
    assign bus.res_id    = id;
    assign bus.res_p     = p_q;
    assign bus.res_err   = err_q;
endmodule
